// File: rtl/multicycle_demux_pkg.sv
// multicycle_pkg: shared definitions for the multicycle demux.
//   state_t        : routing FSM state (IDLE, LOCKED)
//   DEST_0, DEST_1 : destination select encodings
package multicycle_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic DEST_0 = 1'b0;
  localparam logic DEST_1 = 1'b1;

endpackage

// File: rtl/multicycle_demux_if.sv
// multicycle_demux_if: handshake bundle between source, demux and both sinks.
//   in_*    : source beat (data/valid/sel/last) and in_ready back to the source
//   outN_*  : destination N beat (data/valid/last) and outN_ready from the sink
// Modports: slave = demux side, master = source/sink driver side.
interface multicycle_demux_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sel;
  logic             in_last;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_last;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_last;
  logic             out1_ready;

  modport slave (
    input  in_data, in_valid, in_sel, in_last, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out0_last,
           out1_data, out1_valid, out1_last
  );

  modport master (
    output in_data, in_valid, in_sel, in_last, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out0_last,
           out1_data, out1_valid, out1_last
  );
endinterface

// File: rtl/multicycle_demux_slot.sv
// multicycle_slot: one registered output slot (data, last, valid).
//   clk, rst      : clock, synchronous active-high reset
//   fill_i        : load data_i/last_i this cycle (caller only fills when ready_o)
//   data_i/last_i : beat to load
//   out_ready_i   : downstream accepts the held beat
//   ready_o       : slot can take a beat (empty, or draining this cycle)
//   data_o/last_o/valid_o : held beat
module multicycle_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             out_ready_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  // drain-and-refill: a full slot draining this cycle can take a new beat
  assign ready_o = !valid_q || out_ready_i;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (fill_i) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/multicycle_demux.sv
// multicycle_demux: 1-to-2 packet demux with one registered slot per output.
// The destination is taken from in_sel on the first beat of a packet and held
// until the beat with in_last=1 is accepted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : multicycle_demux_if.slave (source beat in, two destinations out)
//   cnt0/1   : packets completed per destination (only with MULTICYCLE_DEMUX_STATS_EN)
// Optional feature macro: MULTICYCLE_DEMUX_STATS_EN (packet counters).
module multicycle_demux
  import multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_demux_if.slave    bus
`ifdef MULTICYCLE_DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
`endif
);
  state_t state_q, state_d;
  logic   lock_sel_q, lock_sel_d;
  logic   dest, accept;

  logic [1:0]            slot_rdy, slot_fill, slot_vld, slot_last, out_rdy;
  logic [1:0][WIDTH-1:0] slot_data;

  assign out_rdy = {bus.out1_ready, bus.out0_ready};

  // only the selected slot gates the input; a stall elsewhere is irrelevant
  assign dest         = (state_q == LOCKED) ? lock_sel_q : bus.in_sel;
  assign bus.in_ready = !rst && ((dest == DEST_1) ? slot_rdy[1] : slot_rdy[0]);
  assign accept       = bus.in_valid && bus.in_ready;

  assign slot_fill[0] = accept && (dest == DEST_0);
  assign slot_fill[1] = accept && (dest == DEST_1);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    multicycle_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .fill_i      (slot_fill[g]),
      .data_i      (bus.in_data),
      .last_i      (bus.in_last),
      .out_ready_i (out_rdy[g]),
      .ready_o     (slot_rdy[g]),
      .data_o      (slot_data[g]),
      .last_o      (slot_last[g]),
      .valid_o     (slot_vld[g])
    );
  end

  assign bus.out0_data  = slot_data[0];
  assign bus.out0_last  = slot_last[0];
  assign bus.out0_valid = slot_vld[0];
  assign bus.out1_data  = slot_data[1];
  assign bus.out1_last  = slot_last[1];
  assign bus.out1_valid = slot_vld[1];

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !bus.in_last) begin
          state_d    = LOCKED;
          lock_sel_d = dest;
        end
      end
      LOCKED: begin
        if (accept && bus.in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= DEST_0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

`ifdef MULTICYCLE_DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // counters wrap naturally at 2^CNT_W
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (slot_fill[0] && bus.in_last) cnt0_d = cnt0_q + 1'b1;
    if (slot_fill[1] && bus.in_last) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_multicycle_demux.sv
// Directed bench for multicycle_demux. Inputs change and outputs are checked
// on the falling edge; the DUT registers on the rising edge.
module tb_multicycle_demux;
  localparam int WIDTH = 32;
`ifdef MULTICYCLE_DEMUX_STATS_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] cnt0, cnt1;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_demux_if #(.WIDTH(WIDTH)) bus ();

  multicycle_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave)
`ifdef MULTICYCLE_DEMUX_STATS_EN
    ,
    .cnt0 (cnt0),
    .cnt1 (cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: rising edge registers, then back to the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic v, input logic sel, input logic last,
                      input logic [WIDTH-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_last  = last;
    bus.in_data  = d;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b0;
    bus.in_last    = 1'b1;
    bus.in_data    = 32'hDEAD_BEEF;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // reset: handshakes ignored, everything cleared
    step(); step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_v0", bus.out0_valid, 0);
    chk("rst_v1", bus.out1_valid, 0);
    chk("rst_d0", bus.out0_data, 0);
    chk("rst_l0", bus.out0_last, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("idle_in_ready", bus.in_ready, 1);

    // single beat to out1
    beat(1, 1, 1, 32'hA5A5_A5A5);
    chk("single_v1", bus.out1_valid, 1);
    chk("single_d1", bus.out1_data, 32'hA5A5_A5A5);
    chk("single_v0", bus.out0_valid, 0);
    beat(0, 0, 0, 0);
    chk("single_drain", bus.out1_valid, 0);

    // packet lock: in_sel flips mid-packet, beats stay on out0
    beat(1, 0, 0, 32'h11);
    chk("lock_b1_v", bus.out0_valid, 1);
    chk("lock_b1_d", bus.out0_data, 32'h11);
    beat(1, 1, 0, 32'h22);
    chk("lock_b2_d", bus.out0_data, 32'h22);
    chk("lock_b2_v1", bus.out1_valid, 0);
    beat(1, 1, 1, 32'h33);
    chk("lock_b3_d", bus.out0_data, 32'h33);
    chk("lock_b3_l", bus.out0_last, 1);
    chk("lock_b3_v1", bus.out1_valid, 0);
    // back in IDLE: in_sel=1 routes to out1 again
    beat(1, 1, 1, 32'h44);
    chk("lock_idle_v1", bus.out1_valid, 1);
    chk("lock_idle_d1", bus.out1_data, 32'h44);
    chk("lock_idle_v0", bus.out0_valid, 0);
    beat(0, 0, 0, 0);

    // backpressure on out0; out1 keeps flowing
    bus.out0_ready = 1'b0;
    beat(1, 0, 1, 32'hB0);
    chk("bp_v0", bus.out0_valid, 1);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    #1 chk("bp_in_ready_sel0", bus.in_ready, 0);
    bus.in_sel   = 1'b1;
    #1 chk("bp_in_ready_sel1", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      beat(1, 1, 1, 32'hC0 + i);
      chk("bp_v1", bus.out1_valid, 1);
      chk("bp_d1", bus.out1_data, 32'hC0 + i);
      chk("bp_hold_d0", bus.out0_data, 32'hB0);
      chk("bp_hold_v0", bus.out0_valid, 1);
    end
    beat(1, 0, 1, 32'hDD);   // refused: slot 0 full and stalled
    chk("bp_no_overwrite", bus.out0_data, 32'hB0);
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    #1 chk("bp_refill_ready", bus.in_ready, 1);
    beat(1, 0, 1, 32'hE0);   // drain and refill in one cycle
    chk("bp_refill_d0", bus.out0_data, 32'hE0);
    chk("bp_refill_v0", bus.out0_valid, 1);
    beat(0, 0, 0, 0);
    chk("bp_drained", bus.out0_valid, 0);

    // throughput: 8 back-to-back beats, one per cycle
    for (int i = 0; i < 8; i++) begin
      beat(1, 1, 1, 32'h100 + i);
      chk("tput_v1", bus.out1_valid, 1);
      chk("tput_d1", bus.out1_data, 32'h100 + i);
    end
    beat(0, 0, 0, 0);
    chk("tput_end", bus.out1_valid, 0);

    // reset mid-packet
    beat(1, 1, 0, 32'h41);
    beat(1, 1, 0, 32'h42);
    chk("mid_d1", bus.out1_data, 32'h42);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    #1 chk("mid_rst_ready", bus.in_ready, 0);
    step();
    chk("mid_v0", bus.out0_valid, 0);
    chk("mid_v1", bus.out1_valid, 0);
    chk("mid_d1_clr", bus.out1_data, 0);
    rst = 1'b0;
    beat(1, 0, 1, 32'h55);
    chk("mid_after_v0", bus.out0_valid, 1);
    chk("mid_after_d0", bus.out0_data, 32'h55);
    chk("mid_after_v1", bus.out1_valid, 0);
    beat(0, 0, 0, 0);

`ifdef MULTICYCLE_DEMUX_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt0_rst", cnt0, 0);
    beat(1, 0, 0, 32'h1);    // multi-beat packet counts once
    chk("cnt0_mid", cnt0, 0);
    beat(1, 1, 1, 32'h2);
    chk("cnt0_one", cnt0, 1);
    for (int i = 1; i < 17; i++) beat(1, 0, 1, i);
    chk("cnt0_wrap", cnt0, 1);
    chk("cnt1_zero", cnt1, 0);
    beat(1, 1, 1, 32'h3);
    chk("cnt1_one", cnt1, 1);
    beat(0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_demux.md
MULTICYCLE_DEMUX -- requirements
Module: multicycle_demux

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data path width in bits.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of each transfer counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-005 in_data  input  WIDTH  SHALL carry the source beat.
REQ-006 in_valid  input  1  SHALL flag that in_data, in_sel and in_last are valid.
REQ-007 in_sel  input  1  SHALL select the destination: 0 selects out0, 1 selects out1.
REQ-008 in_last  input  1  SHALL mark the final beat of a packet.
REQ-009 in_ready  output  1  SHALL flag that the beat is accepted this cycle.
REQ-010 outN_data  output  WIDTH  SHALL carry the data for destination N (N = 0, 1).
REQ-011 outN_valid  output  1  SHALL flag a valid beat on destination N.
REQ-012 outN_last  output  1  SHALL carry the packet-end flag for destination N.
REQ-013 outN_ready  input  1  SHALL flag that destination N accepts its beat.
REQ-014 cnt0, cnt1  output  CNT_W  SHALL hold the packet counters; these ports exist only when MULTICYCLE_DEMUX_STATS_EN is defined.

Function
REQ-015 Each output SHALL have one registered slot; an accepted beat SHALL appear on outN_valid exactly 1 cycle after acceptance.
REQ-016 Transfer SHALL occur only when valid and ready are both high in the same cycle, on the input and on each output.
REQ-017 Slot N SHALL be ready when it is empty, or when outN_valid and outN_ready are both high in that cycle (drain-and-refill, so full throughput is 1 beat per cycle).
REQ-018 The FSM SHALL have two states, IDLE and LOCKED, with the following behaviour:
- IDLE: the destination is in_sel.
- Accepting a beat with in_last=0 SHALL latch the destination (lock_sel) and move the FSM to LOCKED.
- Accepting a beat with in_last=1 SHALL leave the FSM in IDLE.
REQ-019 In LOCKED, the destination SHALL be lock_sel and in_sel SHALL be ignored; accepting a beat with in_last=1 SHALL return the FSM to IDLE.
REQ-020 in_ready SHALL equal the ready of the currently selected slot only, and SHALL be purely combinational from state and outN_ready; it SHALL NOT depend on in_valid.
REQ-021 A stall on the non-selected output SHALL NOT block the input.
REQ-022 Both outputs MAY drain in the same cycle that the input fills one of them.
REQ-023 outN_data and outN_last SHALL hold stable while outN_valid=1 and outN_ready=0.
REQ-024 A slot SHALL never be overwritten while it is full and not draining.

Reset
REQ-025 In any cycle with rst=1, the block SHALL apply the following reset values and ignore all handshakes:
- FSM to IDLE, lock_sel=0;
- out0_valid and out1_valid = 0;
- outN_data and outN_last = 0;
- cnt0 and cnt1 = 0.
REQ-026 Reset mid-packet SHALL discard any in-flight slot contents; the first beat after reset SHALL be routed by in_sel.
REQ-027 While rst=1, in_ready SHALL be 0.

Configuration
REQ-028 When MULTICYCLE_DEMUX_STATS_EN is defined, the block SHALL behave as follows:
- cntN SHALL increment by 1 on each accepted input beat with in_last=1 routed to N.
- Each counter SHALL wrap modulo 2^CNT_W.
REQ-029 When MULTICYCLE_DEMUX_STATS_EN is undefined, the counter ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package multicycle_pkg SHALL hold the following:
- the FSM state typedef (IDLE, LOCKED);
- the destination constants DEST_0=0 and DEST_1=1.
REQ-031 A sub-module multicycle_slot SHALL implement one output register slot (data, last, valid, ready logic), parameterised by WIDTH, instantiated twice.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Single beat: after reset, in_sel=1, in_last=1, in_data=0xA5A5A5A5, out1_ready=1 -> next cycle out1_valid=1 with data 0xA5A5A5A5; out0_valid stays 0.
- Packet lock: a 3-beat packet with in_sel=0 on beat 1, then in_sel toggled to 1 on beats 2-3 -> all 3 beats appear on out0 in order; FSM back in IDLE after beat 3.
- Backpressure: out0_ready=0 with slot 0 full -> in_ready=0 for sel=0; the held data does not change; in_sel=1 beats still flow to out1 at 1 per cycle.
- Throughput: 8 back-to-back single-beat packets to out1 with out1_ready=1 -> 8 beats on 8 consecutive cycles, no bubbles.
- Reset mid-packet: assert rst after beat 2 of a 4-beat packet routed to out1 -> all valids 0; the next beat with in_sel=0 goes to out0.
- Stats (MULTICYCLE_DEMUX_STATS_EN defined, CNT_W=4): 17 packets to out0 -> cnt0=1 after wrap; cnt1=0.
